instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 10, as the word-address width of the target instruction memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: pulse that begins a new program load.
REQ-005 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: the field-tuple handshake.
REQ-006 The block SHALL have port fmt, input, 3 bits: instruction format, where 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, and 6-7 are invalid.
REQ-007 The block SHALL have these field inputs: opcode [6:0], rd [4:0], rs1 [4:0], rs2 [4:0], func3 [2:0], func7 [6:0], and imm [31:0] (signed byte offset or value).
REQ-008 The block SHALL have port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 The block SHALL have port mem_addr, output, ADDR_W bits: word address.
REQ-010 The block SHALL have port mem_wdata, output, 32 bits: the encoded instruction.
REQ-011 The block SHALL have port count, output, ADDR_W+1 bits: the number of words written since start.
REQ-012 The block SHALL have these status outputs, 1 bit each: full (memory exhausted) and err (sticky encoding error).

Function
REQ-013 The block SHALL implement FSM states IDLE, LOAD and FULL.
REQ-014 In IDLE, start SHALL move the FSM to LOAD and clear count, the address and err.
REQ-015 In LOAD or FULL, start SHALL perform the same restart and take priority over a same-cycle handshake, which is dropped.
REQ-016 The block SHALL assert in_ready only in state LOAD with start low; the tuple is accepted on an edge where in_valid and in_ready are both high.
REQ-017 A tuple accepted at edge N SHALL produce mem_we=1 for exactly the cycle after edge N, with mem_wdata = its encoding and mem_addr = count before increment; the latency is 1 cycle.
REQ-018 The block SHALL sustain one accepted tuple per cycle, with no bubbles.
REQ-019 For every format, the encoder SHALL place opcode at [6:0].
REQ-020 R format SHALL encode as func7[31:25], rs2[24:20], rs1[19:15], func3[14:12], rd[11:7].
REQ-021 I format SHALL encode as imm[11:0] at [31:20], plus rs1, func3 and rd.
REQ-022 S format SHALL encode as imm[11:5] at [31:25], rs2, rs1, func3, and imm[4:0] at [11:7].
REQ-023 B format SHALL encode as imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], from bit 31 downward.
REQ-024 U format SHALL encode as imm[31:12] at [31:12], plus rd.
REQ-025 J format SHALL encode as imm[20], imm[10:1], imm[11], imm[19:12], rd, from bit 31 downward.
REQ-026 An immediate-range violation SHALL set err; the word is still written with the truncated immediate. The violations are:
  - I/S: imm is not the sign-extension of its low 12 bits.
  - B: imm is not the sign-extension of its low 13 bits, or imm[0]=1.
  - J: imm is not the sign-extension of its low 21 bits, or imm[0]=1.
  - U: imm[11:0] is nonzero.
REQ-027 Invalid fmt (6-7) SHALL write 32'h00000013 (NOP) and set err.
REQ-028 The encoder SHALL ignore fields unused by the selected format.
REQ-029 err SHALL remain set until start or reset.
REQ-030 On each write, mem_addr SHALL equal count[ADDR_W-1:0], and count SHALL increment by 1.
REQ-031 When count reaches 2^ADDR_W, the FSM SHALL enter FULL and assert full; in_ready goes low in the same cycle the last tuple is accepted, so the address never wraps.
REQ-032 mem_we SHALL be 0 in every cycle not following an accept.

Reset
REQ-033 While rst_n=0, the block SHALL hold state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0 and err=0.
REQ-034 Reset asserted mid-load SHALL abort any pending write; no mem_we pulse follows reset deassertion.
REQ-035 After reset, the block SHALL accept no tuples until start.

Structure
REQ-036 The fmt encodings, the opcode constants (OP_REG 0110011, OP_IMM 0010011, OP_STORE 0100011, OP_BRANCH 1100011, OP_LUI 0110111, OP_JAL 1101111) and the NOP value SHALL reside in the shared package riscv_pkg.
REQ-037 Field packing and range checking SHALL be a combinational sub-module instr_pack, outputting word[31:0] and imm_bad.
REQ-038 The FSM, counter and output registers SHALL reside in instruction_encoder.

Verification
REQ-039 The bench SHALL cover an R-type tuple: fmt=0, opcode=0110011, rd=3, rs1=1, rs2=2, func3=0, func7=0 -> mem_wdata=0x002081B3 at address 0, with err=0.
REQ-040 The bench SHALL cover I- and S-type tuples: I with rd=5, rs1=0, imm=-1, opcode 0010011 -> 0xFFF00293; S with rs1=1, rs2=2, func3=2, imm=8 -> 0x0020A423.
REQ-041 The bench SHALL cover B-, J- and U-type tuples: B with imm=-4, rs1=rs2=0 -> 0xFE000EE3; J with rd=1, imm=8 -> 0x008000EF; U with rd=1, imm=0x12345000 -> 0x123450B7.
REQ-042 The bench SHALL cover an error case: B with imm=3 -> word is written, err=1, and err stays 1 until start; fmt=7 -> 0x00000013.
REQ-043 The bench SHALL cover overflow with ADDR_W=2: 5 back-to-back valid tuples -> 4 writes at addresses 0-3, full=1 and in_ready=0 after the 4th accept, and the 5th tuple is never written.
REQ-044 The bench SHALL cover a mid-stream restart: start is pulsed while in_valid=1 after 2 writes -> no write that cycle, count=0, and the next tuple is written at address 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants: instruction format codes, base opcodes and the canonical NOP.
package riscv_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit instruction word for a format and flags
// immediates that do not fit the format's encodable range.
module instr_pack
   import riscv_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        imm_bad
);

   always_comb begin
      // NOTE: both outputs get a default before the case so no path through it can infer a latch.
      word    = NOP;
      imm_bad = 1'b0;
      case (fmt)
         FMT_R: word = {func7, rs2, rs1, func3, rd, opcode};
         FMT_I: begin
            word    = {imm[11:0], rs1, func3, rd, opcode};
            imm_bad = imm != {{20{imm[11]}}, imm[11:0]};
         end
         FMT_S: begin
            word    = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            imm_bad = imm != {{20{imm[11]}}, imm[11:0]};
         end
         FMT_B: begin
            word    = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            imm_bad = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
         end
         FMT_U: begin
            word    = {imm[31:12], rd, opcode};
            imm_bad = |imm[11:0];
         end
         FMT_J: begin
            word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            imm_bad = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
         end
         // Codes 6 and 7 have no format: emit a harmless NOP and flag it.
         default: imm_bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/instruction_encoder.sv
// Streams field tuples into an instruction memory: encodes each accepted tuple and writes it
// one cycle later at the next sequential word address, stopping once the memory is full.
module instruction_encoder
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        func3,
   input  logic [6:0]        func7,
   input  logic [31:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, LOAD, FULL} state_e;

   localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

   state_e      state;
   logic        accept;
   logic [31:0] word;
   logic        imm_bad;

   instr_pack u_pack (
      .fmt     (fmt),
      .opcode  (opcode),
      .rd      (rd),
      .rs1     (rs1),
      .rs2     (rs2),
      .func3   (func3),
      .func7   (func7),
      .imm     (imm),
      .word    (word),
      .imm_bad (imm_bad)
   );

   // A start in the same cycle wins over the handshake, so ready is masked by it.
   assign in_ready = (state == LOAD) && !start;
   assign accept   = in_valid && in_ready;

   // NOTE: all state uses <= so each register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         full      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (start) begin
            state    <= LOAD;
            mem_addr <= '0;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
         end else if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_wdata <= word;
            count     <= count + ONE;
            err       <= err | imm_bad;
            if (count == LAST) begin
               state <= FULL;
               full  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed format/boundary cases plus random traffic, all
// compared every cycle against a transaction-level model of the load sequence.
module tb_instruction_encoder;
   import riscv_pkg::*;

   localparam int ADDR_W = 2;
   localparam int CAP    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        fmt;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        func3;
   logic [6:0]        func7;
   logic [31:0]       imm;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   int n_vec = 0;
   int n_bad = 0;
   bit cmp_on = 1'b0;
   int wr_addr_q[$];

   instruction_encoder #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fmt       (fmt),
      .opcode    (opcode),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .func3     (func3),
      .func7     (func7),
      .imm       (imm),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .count     (count),
      .full      (full),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference encoding, written as shift-and-mask arithmetic on the field values.
   function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [6:0] op,
                                            input logic [4:0] d, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] im);
      logic [31:0] regs;
      logic [31:0] low;
      regs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
      low  = (32'(d) << 7) | 32'(op);
      case (f)
         3'd0: return (32'(f7) << 25) | regs | low;
         3'd1: return ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | low;
         3'd2: return (((im >> 5) & 32'h7F) << 25) | regs | ((im & 32'h1F) << 7) | 32'(op);
         3'd3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs |
                      (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'(op);
         3'd4: return (im & 32'hFFFF_F000) | low;
         3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
                      (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | low;
         default: return 32'h0000_0013;
      endcase
   endfunction

   // Reference range check, expressed as signed numeric bounds and alignment.
   function automatic bit ref_bad(input logic [2:0] f, input logic [31:0] im);
      int s;
      s = $signed(im);
      case (f)
         3'd0:       return 1'b0;
         3'd1, 3'd2: return (s < -2048) || (s > 2047);
         3'd3:       return (s < -4096) || (s > 4095) || ((im & 32'h1) != 0);
         3'd4:       return (im & 32'hFFF) != 0;
         3'd5:       return (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((im & 32'h1) != 0);
         default:    return 1'b1;
      endcase
   endfunction

   // Transaction-level model: loading flag, word count, sticky error, and the pending write.
   bit          m_loading = 1'b0;
   bit          m_full    = 1'b0;
   bit          m_err     = 1'b0;
   bit          m_we      = 1'b0;
   int          m_count   = 0;
   int          m_addr    = 0;
   logic [31:0] m_word    = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_loading <= 1'b0;
         m_full    <= 1'b0;
         m_err     <= 1'b0;
         m_we      <= 1'b0;
         m_count   <= 0;
         m_addr    <= 0;
         m_word    <= '0;
      end else begin
         m_we <= 1'b0;
         if (start) begin
            m_loading <= 1'b1;
            m_full    <= 1'b0;
            m_err     <= 1'b0;
            m_count   <= 0;
         end else if (m_loading && in_valid) begin
            m_we    <= 1'b1;
            m_addr  <= m_count;
            m_word  <= ref_word(fmt, opcode, rd, rs1, rs2, func3, func7, imm);
            m_err   <= m_err || ref_bad(fmt, imm);
            m_count <= m_count + 1;
            if (m_count + 1 == CAP) begin
               m_loading <= 1'b0;
               m_full    <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("in_ready", 32'(in_ready), 32'(m_loading && !start));
         check("mem_we", 32'(mem_we), 32'(m_we));
         check("count", 32'(count), 32'(m_count));
         check("full", 32'(full), 32'(m_full));
         check("err", 32'(err), 32'(m_err));
         if (m_we || !rst_n) begin
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_wdata", mem_wdata, m_word);
         end
         if (mem_we) wr_addr_q.push_back(int'(mem_addr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_tuple(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
      fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
      in_valid = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic expect_write(input string name, input logic [31:0] word, input int addr);
      check({name, " we"}, 32'(mem_we), 32'd1);
      check({name, " word"}, mem_wdata, word);
      check({name, " addr"}, 32'(mem_addr), 32'(addr));
   endtask

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($signed($urandom_range(0, 10000)) - 5000);
         2:       return 32'(($signed($urandom_range(0, 4000)) - 2000) * 2);
         default: return $urandom & 32'hFFFF_F000;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      set_tuple(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      in_valid = 1'b0;
      cmp_on = 1'b1;
      repeat (3) tick();
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      tick();

      // No accepts before the first start.
      set_tuple(3'd0, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      repeat (3) tick();
      check("pre-start we", 32'(mem_we), 32'd0);
      check("pre-start count", 32'(count), 32'd0);

      // The tuple is still presented during the start cycle and is dropped there.
      pulse_start();
      check("start drops tuple", 32'(mem_we), 32'd0);
      tick();
      expect_write("R", 32'h002081B3, 0);
      check("R err", 32'(err), 32'd0);
      set_tuple(3'd1, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
      tick();
      expect_write("I", 32'hFFF00293, 1);
      set_tuple(3'd2, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
      tick();
      expect_write("S", 32'h0020A423, 2);
      set_tuple(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
      tick();
      expect_write("B", 32'hFE000EE3, 3);
      check("B full", 32'(full), 32'd1);

      in_valid = 1'b0;
      pulse_start();
      set_tuple(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
      tick();
      expect_write("J", 32'h008000EF, 0);
      set_tuple(3'd4, OP_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      tick();
      expect_write("U", 32'h123450B7, 1);
      check("U err", 32'(err), 32'd0);
      set_tuple(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      tick();
      expect_write("B odd", 32'h00000163, 2);
      check("B odd err", 32'(err), 32'd1);
      in_valid = 1'b0;
      repeat (3) tick();
      check("err sticky", 32'(err), 32'd1);
      set_tuple(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_FFFF);
      tick();
      expect_write("fmt7", 32'h00000013, 3);
      in_valid = 1'b0;
      pulse_start();
      check("start clears err", 32'(err), 32'd0);
      check("start clears count", 32'(count), 32'd0);

      // Overflow: five back-to-back tuples into a four-word memory.
      wr_addr_q.delete();
      for (int i = 0; i < 5; i++) begin
         set_tuple(3'd0, OP_REG, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
         tick();
         if (i == 3) begin
            check("ovf full", 32'(full), 32'd1);
            check("ovf ready", 32'(in_ready), 32'd0);
         end
      end
      in_valid = 1'b0;
      tick();
      check("ovf count", 32'(count), 32'd4);
      check("ovf writes", 32'(wr_addr_q.size()), 32'd4);
      for (int i = 0; i < wr_addr_q.size() && i < 4; i++)
         check("ovf addr", 32'(wr_addr_q[i]), 32'(i));

      // Restart in the middle of a stream with a valid tuple presented.
      pulse_start();
      set_tuple(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
      repeat (2) tick();
      start = 1'b1;
      tick();
      check("restart we", 32'(mem_we), 32'd0);
      check("restart count", 32'(count), 32'd0);
      start = 1'b0;
      tick();
      check("restart addr", 32'(mem_addr), 32'd0);
      check("restart next we", 32'(mem_we), 32'd1);
      in_valid = 1'b0;

      // Reset asserted while a write is on the bus.
      pulse_start();
      set_tuple(3'd0, OP_REG, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
      tick();
      rst_n = 1'b0;
      #1;
      check("abort we", 32'(mem_we), 32'd0);
      check("abort count", 32'(count), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("post-reset we", 32'(mem_we), 32'd0);
      check("post-reset count", 32'(count), 32'd0);
      in_valid = 1'b0;

      // Random traffic with occasional restarts.
      for (int i = 0; i < 3000; i++) begin
         set_tuple(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
         in_valid = ($urandom_range(0, 3) != 0);
         start    = ($urandom_range(0, 15) == 0);
         tick();
      end
      start = 1'b0;
      in_valid = 1'b0;
      repeat (2) tick();
      cmp_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
